hub75_scanner: RTL and testbench

Parametrised HUB75 panel scan engine replacing the fixed-geometry, 1-bit-colour `led_shifter`. It walks every scan row and every colour bit-plane, reads pixels through `x`/`y` from a frame-buffer port with one-cycle read latency, and shifts them out on `led_clk`. Per-plane binary-coded-modulation (BCM) on-times give `COLOR_BITS` of intensity per channel. It sits between `clock_divider`/`frame_buffer` and the panel pins in `driver`.

---
 rtl/hub75_scanner.sv | 203 ++++++++++++++++++++
 tb/tb_hub75_scanner.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hub75_scanner.sv
// HUB75 scan engine: walks rows and BCM bit-planes, shifts pixels from a
// one-cycle-latency frame buffer onto the panel, then latches and displays.
module hub75_scanner #(
  parameter int PANEL_WIDTH = 64,
  parameter int SCAN_ROWS   = 16,
  parameter int COLOR_BITS  = 4,
  parameter int CLK_DIV     = 2,
  parameter int ON_TIME     = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                enable,
  input  logic [3*COLOR_BITS-1:0]                             rgb_top,
  input  logic [3*COLOR_BITS-1:0]                             rgb_bot,
  output logic [$clog2(PANEL_WIDTH)-1:0]                      x,
  output logic [((SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1)-1:0]   y,
  output logic [((COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1)-1:0] plane,
  output logic                                                r1,
  output logic                                                g1,
  output logic                                                b1,
  output logic                                                r2,
  output logic                                                g2,
  output logic                                                b2,
  output logic                                                led_clk,
  output logic                                                led_latch,
  output logic                                                led_oe,
  output logic [((SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1)-1:0]   dmux,
  output logic                                                frame_done
);

  localparam int XW  = $clog2(PANEL_WIDTH);
  localparam int YW  = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1;
  localparam int PLW = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int PHW = $clog2(2 * CLK_DIV);
  localparam int CW  = $clog2((ON_TIME << (COLOR_BITS - 1)) + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

  state_t         r_state, w_state;
  logic [PHW-1:0] r_phase, w_phase;
  logic [XW-1:0]  r_x, w_x;
  logic [YW-1:0]  r_y, w_y, r_dmux, w_dmux;
  logic [PLW-1:0] r_plane, w_plane;
  logic [CW-1:0]  r_cnt, w_cnt, w_on_last;
  logic           r_last_col, w_last_col, r_wrapped, w_wrapped;
  logic           r_led_clk, w_led_clk, r_led_latch, w_led_latch;
  logic           r_led_oe, w_led_oe, r_frame_done, w_frame_done;
  logic [5:0]     r_data, w_data;
  logic           w_adv_row;

  function automatic logic plane_bit(input logic [COLOR_BITS-1:0] ch,
                                     input logic [PLW-1:0] p);
    return ch[p];
  endfunction

  assign w_on_last = (CW'(ON_TIME) << r_plane) - CW'(1);

  // The row address moves one cycle before the last display cycle ends so the
  // frame buffer already returns the new row in the first shift cycle.
  always_comb begin
    w_adv_row = 1'b0;
    if (r_plane == PLW'(COLOR_BITS - 1)) begin
      if (r_state == S_LATCH && r_phase == PHW'(1) && w_on_last == '0)
        w_adv_row = 1'b1;
      if (r_state == S_DISPLAY && (r_cnt + CW'(1)) == w_on_last)
        w_adv_row = 1'b1;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_phase      = r_phase;
    w_x          = r_x;
    w_y          = r_y;
    w_dmux       = r_dmux;
    w_plane      = r_plane;
    w_cnt        = r_cnt;
    w_last_col   = r_last_col;
    w_wrapped    = r_wrapped;
    w_led_clk    = 1'b0;
    w_led_latch  = 1'b0;
    w_led_oe     = 1'b1;
    w_frame_done = 1'b0;
    w_data       = r_data;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state = S_SHIFT;
          w_phase = '0;
        end
      end
      S_SHIFT: begin
        // x is issued one step ahead so the next column's read is settled
        // by the time its capture cycle comes round.
        if (r_phase == '0) begin
          w_data = {plane_bit(rgb_top[2*COLOR_BITS +: COLOR_BITS], r_plane),
                    plane_bit(rgb_top[COLOR_BITS +: COLOR_BITS], r_plane),
                    plane_bit(rgb_top[0 +: COLOR_BITS], r_plane),
                    plane_bit(rgb_bot[2*COLOR_BITS +: COLOR_BITS], r_plane),
                    plane_bit(rgb_bot[COLOR_BITS +: COLOR_BITS], r_plane),
                    plane_bit(rgb_bot[0 +: COLOR_BITS], r_plane)};
          w_last_col = (r_x == XW'(PANEL_WIDTH - 1));
          w_x        = w_last_col ? '0 : r_x + XW'(1);
        end
        if (r_phase == PHW'(2 * CLK_DIV - 1)) begin
          w_phase = '0;
          if (r_last_col) begin
            w_state     = S_LATCH;
            w_led_latch = 1'b1;
            w_dmux      = r_y;
            w_last_col  = 1'b0;
          end
        end else begin
          w_phase   = r_phase + PHW'(1);
          w_led_clk = (w_phase >= PHW'(CLK_DIV));
        end
      end
      S_LATCH: begin
        if (r_phase == '0) begin
          w_phase = PHW'(1);
        end else begin
          w_state  = S_DISPLAY;
          w_phase  = '0;
          w_cnt    = '0;
          w_led_oe = 1'b0;
        end
      end
      S_DISPLAY: begin
        if (r_cnt == w_on_last) begin
          w_cnt     = '0;
          w_plane   = (r_plane == PLW'(COLOR_BITS - 1)) ? '0 : r_plane + PLW'(1);
          w_wrapped = 1'b0;
          if (r_wrapped && !enable) begin
            w_state = S_IDLE;
            w_data  = '0;
            w_dmux  = '0;
          end else begin
            w_state = S_SHIFT;
            w_phase = '0;
          end
        end else begin
          w_cnt    = r_cnt + CW'(1);
          w_led_oe = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase
    if (w_adv_row) begin
      if (r_y == YW'(SCAN_ROWS - 1)) begin
        w_y          = '0;
        w_frame_done = 1'b1;
        w_wrapped    = 1'b1;
      end else begin
        w_y = r_y + YW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_dmux       <= '0;
      r_plane      <= '0;
      r_cnt        <= '0;
      r_last_col   <= 1'b0;
      r_wrapped    <= 1'b0;
      r_led_clk    <= 1'b0;
      r_led_latch  <= 1'b0;
      r_led_oe     <= 1'b1;
      r_frame_done <= 1'b0;
      r_data       <= '0;
    end else begin
      r_state      <= w_state;
      r_phase      <= w_phase;
      r_x          <= w_x;
      r_y          <= w_y;
      r_dmux       <= w_dmux;
      r_plane      <= w_plane;
      r_cnt        <= w_cnt;
      r_last_col   <= w_last_col;
      r_wrapped    <= w_wrapped;
      r_led_clk    <= w_led_clk;
      r_led_latch  <= w_led_latch;
      r_led_oe     <= w_led_oe;
      r_frame_done <= w_frame_done;
      r_data       <= w_data;
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign plane      = r_plane;
  assign dmux       = r_dmux;
  assign {r1, g1, b1, r2, g2, b2} = r_data;
  assign led_clk    = r_led_clk;
  assign led_latch  = r_led_latch;
  assign led_oe     = r_led_oe;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hub75_scanner.sv
// Directed bench for hub75_scanner on a 4x(2x2) panel with 2-bit colour.
module tb_hub75_scanner;
  localparam int PW = 4, SR = 2, CB = 2, CD = 2, OT = 3;
  localparam logic [14:0] RST_VEC = {6'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b0, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst, enable;
  logic [3*CB-1:0] rgb_top, rgb_bot;
  logic [1:0] x;
  logic y, plane, dmux;
  logic r1, g1, b1, r2, g2, b2;
  logic led_clk, led_latch, led_oe, frame_done;

  int checks = 0;
  int failures = 0;
  int mode = 0;

  logic [5:0] t_dat [0:99];
  logic t_clk [0:99];
  logic t_lat [0:99];
  logic t_oe  [0:99];
  logic t_fd  [0:99];
  logic t_y   [0:99];
  logic t_pl  [0:99];
  logic t_dm  [0:99];

  always #5 clk = ~clk;

  // Frame buffer model with one cycle of read latency.
  always @(posedge clk) begin
    if (mode == 0) begin
      rgb_top <= 6'b10_00_00;
      rgb_bot <= 6'b00_00_01;
    end else begin
      rgb_top <= {x, ~x, 2'b00};
      rgb_bot <= {2'b00, {2{y}}, 2'b00};
    end
  end

  hub75_scanner #(
    .PANEL_WIDTH(PW), .SCAN_ROWS(SR), .COLOR_BITS(CB), .CLK_DIV(CD), .ON_TIME(OT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .rgb_top(rgb_top), .rgb_bot(rgb_bot),
    .x(x), .y(y), .plane(plane), .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .led_clk(led_clk), .led_latch(led_latch), .led_oe(led_oe), .dmux(dmux),
    .frame_done(frame_done)
  );

  function automatic logic [14:0] obs_all();
    return {r1, g1, b1, r2, g2, b2, led_clk, led_latch, led_oe, frame_done, x, y, plane, dmux};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic record(input int c);
    t_dat[c] = {r1, g1, b1, r2, g2, b2};
    t_clk[c] = led_clk;
    t_lat[c] = led_latch;
    t_oe[c]  = led_oe;
    t_fd[c]  = frame_done;
    t_y[c]   = y;
    t_pl[c]  = plane;
    t_dm[c]  = dmux;
  endtask

  initial begin
    int n;
    int cyc;
    logic b;
    rst = 1'b1;
    enable = 1'b0;
    mode = 0;
    repeat (3) tick();
    chk("reset_outputs", 32'(obs_all()), 32'(RST_VEC));
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_without_enable", 32'(obs_all()), 32'(RST_VEC));

    // Frame 1: constant colours, enable dropped during row 0.
    enable = 1'b1;
    tick();
    for (int c = 0; c < 100; c++) begin
      if (c == 10) enable = 1'b0;
      record(c);
      tick();
    end

    for (int c = 0; c < 16; c++)
      chk($sformatf("p0_ledclk_c%0d", c), 32'(t_clk[c]), 32'((c % 4) >= 2));
    n = 0;
    for (int c = 1; c < 21; c++) if (t_clk[c] && !t_clk[c-1]) n++;
    chk("p0_ledclk_pulses", n, 4);
    n = 0;
    for (int c = 0; c < 21; c++) if (t_lat[c]) n++;
    chk("p0_latch_pulses", n, 1);
    chk("p0_latch_at16", 32'(t_lat[16]), 32'd1);
    n = 0;
    for (int c = 0; c < 21; c++) if (!t_oe[c]) n++;
    chk("p0_oe_low_cycles", n, 3);
    chk("p0_oe_window", 32'({t_oe[17], t_oe[18], t_oe[19], t_oe[20], t_oe[21]}), 32'b10001);
    n = 0;
    for (int c = 21; c < 45; c++) if (!t_oe[c]) n++;
    chk("p1_oe_low_cycles", n, 6);
    chk("p1_latch_at37", 32'(t_lat[37]), 32'd1);
    chk("p1_oe_edges", 32'({t_oe[38], t_oe[39], t_oe[44], t_oe[45]}), 32'b1001);
    chk("plane_sequence", 32'({t_pl[0], t_pl[21], t_pl[45], t_pl[66]}), 32'b0101);
    chk("map_plane0_early", 32'(t_dat[3]), 32'b000001);
    chk("map_plane0_late", 32'(t_dat[20]), 32'b000001);
    chk("map_plane1", 32'(t_dat[24]), 32'b100000);
    chk("dmux_sequence", 32'({t_dm[16], t_dm[37], t_dm[61], t_dm[82]}), 32'b0011);
    chk("y_sequence", 32'({t_y[0], t_y[21], t_y[45], t_y[66]}), 32'b0011);
    n = 0;
    for (int c = 0; c < 100; c++) if (t_fd[c]) n++;
    chk("frame_done_count", n, 1);
    chk("frame_done_at89", 32'(t_fd[89]), 32'd1);
    chk("y_wrapped", 32'(t_y[89]), 32'd0);
    n = 0;
    for (int c = 90; c < 100; c++) if (!t_oe[c] || t_clk[c] || t_lat[c]) n++;
    chk("idle_after_drop", n, 0);
    chk("idle_data_cleared", 32'(t_dat[95]), 32'd0);

    // Frame 2: column/row dependent colours, enable held.
    mode = 1;
    enable = 1'b1;
    tick();
    for (int c = 0; c < 93; c++) begin
      record(c);
      tick();
    end
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 2; p++)
        for (int c = 0; c < 4; c++) begin
          cyc = r * 45 + (p == 1 ? 21 : 0) + 4 * c + 2;
          b = 1'((c >> p) & 1);
          chk($sformatf("latency_r%0d_p%0d_c%0d", r, p, c), 32'({t_clk[cyc], t_dat[cyc]}),
              32'({1'b1, b, ~b, 1'b0, 1'b0, 1'(r), 1'b0}));
        end
    chk("f2_frame_done_at89", 32'(t_fd[89]), 32'd1);
    chk("f2_continues", 32'({t_oe[90], t_pl[90], t_y[90], t_clk[92]}), 32'b1001);

    // Asynchronous reset while led_clk is high in the next frame.
    chk("pre_reset_ledclk_high", 32'(led_clk), 32'd1);
    #2;
    rst = 1'b1;
    enable = 1'b0;
    #1;
    chk("reset_async", 32'(obs_all()), 32'(RST_VEC));
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("reset_idle_hold_%0d", i), 32'(obs_all()), 32'(RST_VEC));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
